csr_commit_sequencer: RTL

//  Commit-stage sequencer for CSR instructions, directly downstream of the single-entry CSR address buffer.
//  - When the ROB head is a CSR op, takes the buffered CSR address and the operand.
//  - Runs a request/response transaction with the CSR register file and writes rd back.
//  - Pulses csr_commit_o to release the buffer entry, then retires the head.
//  - Writes to side-effecting CSRs raise a pipeline flush request; retirement continues only after the flush is acknowledged.

---
 rtl/csr_commit_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/csr_commit_sequencer.sv
// Commit-stage CSR sequencer: issues one CSR file transaction per ROB-head
// CSR op, writes rd back, releases the CSR buffer and handles flush/timeout.
module csr_commit_sequencer #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            commit_valid_i,
    input  logic [1:0]      commit_op_i,
    input  logic [XLEN-1:0] commit_wdata_i,
    input  logic            commit_rs1_zero_i,
    input  logic [4:0]      commit_rd_i,
    input  logic [11:0]     csr_addr_i,
    output logic            commit_ack_o,
    output logic            csr_commit_o,
    output logic            csr_req_valid_o,
    input  logic            csr_req_ready_i,
    output logic [1:0]      csr_op_o,
    output logic [11:0]     csr_addr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    input  logic            csr_rsp_valid_i,
    input  logic [XLEN-1:0] csr_rdata_i,
    input  logic            csr_exception_i,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            exception_o,
    output logic            timeout_o,
    output logic            flush_req_o,
    input  logic            flush_ack_i
);

    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        DRAIN,
        FLUSH
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      rd_q;
    logic [1:0]      eff_op;
    logic            side_fx;
    logic            load;
    logic            ack_d, commit_d, wb_d, exc_d, to_d;

    // SET/CLEAR with a zero operand must not produce a write side effect
    assign eff_op = (commit_op_i[1] & commit_rs1_zero_i) ? 2'b00 : commit_op_i;

    assign side_fx = (csr_op_o != 2'b00) &&
                     ((csr_addr_o == 12'h180) || (csr_addr_o == 12'h300) ||
                      (csr_addr_o == 12'h100) || (csr_addr_o == 12'h301));

    assign csr_req_valid_o = (state_q == REQ);
    assign flush_req_o     = (state_q == FLUSH);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        ack_d    = 1'b0;
        commit_d = 1'b0;
        wb_d     = 1'b0;
        exc_d    = 1'b0;
        to_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (commit_valid_i & ~flush_i & ~commit_ack_o) begin
                    load    = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // an accepted request always gets its response collected
                if (csr_req_ready_i) begin
                    state_d = flush_i ? DRAIN : WAIT_RSP;
                    cnt_d   = '0;
                end else if (flush_i) begin
                    state_d = IDLE;
                end
            end
            WAIT_RSP: begin
                cnt_d = cnt_q + CW'(1);
                if (csr_rsp_valid_i) begin
                    ack_d = 1'b1;
                    if (csr_exception_i) begin
                        exc_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        commit_d = 1'b1;
                        wb_d     = (rd_q != 5'd0);
                        state_d  = side_fx ? FLUSH : IDLE;
                    end
                end else if (flush_i) begin
                    state_d = DRAIN;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    ack_d   = 1'b1;
                    exc_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (csr_rsp_valid_i) state_d = IDLE;
            end
            FLUSH: begin
                if (flush_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rd_q         <= '0;
            csr_op_o     <= '0;
            csr_addr_o   <= '0;
            csr_wdata_o  <= '0;
            commit_ack_o <= 1'b0;
            csr_commit_o <= 1'b0;
            wb_valid_o   <= 1'b0;
            exception_o  <= 1'b0;
            timeout_o    <= 1'b0;
            wb_rd_o      <= '0;
            wb_data_o    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            commit_ack_o <= ack_d;
            csr_commit_o <= commit_d;
            wb_valid_o   <= wb_d;
            exception_o  <= exc_d;
            timeout_o    <= to_d;
            if (load) begin
                csr_op_o    <= eff_op;
                csr_addr_o  <= csr_addr_i;
                csr_wdata_o <= commit_wdata_i;
                rd_q        <= commit_rd_i;
            end
            if (commit_d) begin
                wb_rd_o   <= rd_q;
                wb_data_o <= csr_rdata_i;
            end
        end
    end

endmodule
